// File: rtl/mux_sel_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mux_arb_pkg : shared sizes, FSM encoding and one-hot helper            |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
package mux_arb_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] sel);
      logic [NREQ-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_pick : rotating-priority encoder, search starts just after last_i   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req_i,
   input  logic [SEL_W-1:0] last_i,
   output logic [SEL_W-1:0] winner_o,
   output logic             any_o
);

   logic             w_found;
   logic [SEL_W-1:0] w_idx;

   always_comb begin
      winner_o = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      // index arithmetic wraps naturally in SEL_W bits
      for (int i = 1; i <= NREQ; i++) begin
         w_idx = last_i + SEL_W'(i);
         if (!w_found && req_i[w_idx]) begin
            winner_o = w_idx;
            w_found  = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mux_sel_arbiter : round-robin owner of the mux select, min/max hold    |
// | Revision        : 1.0                                                  |
// +-----------------------------------------------------------------------+
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MIN_HOLD = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [NREQ-1:0]  REQ,
   input  logic             LOCK,
   output logic [NREQ-1:0]  GNT,
   output logic [SEL_W-1:0] SEL,
   output logic             VALID
);

   localparam int               c_cnt_w = $clog2(MAX_HOLD + 1);
   localparam logic [c_cnt_w-1:0] c_min = c_cnt_w'(MIN_HOLD);
   localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_HOLD);
   localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

   state_e             state_q, state_d;
   logic [NREQ-1:0]    gnt_q,   gnt_d;
   logic [SEL_W-1:0]   sel_q,   sel_d;
   logic [SEL_W-1:0]   last_q,  last_d;
   logic               valid_q, valid_d;
   logic [c_cnt_w-1:0] cnt_q,   cnt_d;

   logic [SEL_W-1:0]   w_winner;
   logic               w_any;
   logic               w_release;

   rr_pick u_pick (
      .req_i    (REQ),
      .last_i   (last_q),
      .winner_o (w_winner),
      .any_o    (w_any)
   );

   // last_q always names the current owner while in GRANT
   assign w_release = (!REQ[last_q] && (cnt_q >= c_min)) ||
                      ((cnt_q >= c_max) && !LOCK && (|(REQ & ~onehot(last_q))));

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= SEL_W'(NREQ - 1);
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (w_any)     state_d = GRANT;
         GRANT:   if (w_release) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (w_any) begin
               gnt_d   = onehot(w_winner);
               sel_d   = w_winner;
               last_d  = w_winner;
               valid_d = 1'b1;
               cnt_d   = c_one;
            end
         end
         GRANT: begin
            if (w_release) begin
               gnt_d   = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q != c_max) begin
               cnt_d = cnt_q + c_one;
            end
         end
         default: begin
            gnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign GNT   = gnt_q;
   assign SEL   = sel_q;
   assign VALID = valid_q;

   a_gnt_onehot0: assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
      $onehot0(GNT));
   a_valid_gnt:   assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
      VALID == (|GNT));
   a_sel_stable:  assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
      ($past(VALID) && VALID) |-> (SEL == $past(SEL)));

endmodule
`default_nettype wire
